// File: rtl/mmu_request_arbiter_pkg.sv
// Shared constants for the MMU request arbiter and its owner queue.
// Contents:
//   L_PARAM_OWNER_IF / L_PARAM_OWNER_LS : owner IDs stored in the owner queue.
//   L_PARAM_IF_ORDER                    : access order driven for every fetch.
package mmu_request_arbiter_pkg;

  localparam logic L_PARAM_OWNER_IF = 1'b0;
  localparam logic L_PARAM_OWNER_LS = 1'b1;

  localparam logic [1:0] L_PARAM_IF_ORDER = 2'h2;

endpackage

// File: rtl/mmu_arbiter_owner_fifo.sv
// In-order owner queue: one bit per outstanding read, naming the requester that
// will receive the next read return.
// Ports:
//   iCLOCK, inRESET : clock, asynchronous active-low reset (empties the queue)
//   iPUSH, iDATA    : push owner ID (ignored when full)
//   iPOP            : pop head (ignored when empty)
//   oFULL, oEMPTY   : occupancy flags
//   oHEAD           : owner ID at the head
module mmu_arbiter_owner_fifo #(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned QUEUE_PTR   = 3
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iPUSH,
  input  logic iDATA,
  input  logic iPOP,
  output logic oFULL,
  output logic oEMPTY,
  output logic oHEAD
);

  localparam logic [QUEUE_PTR:0] L_FULL_COUNT = QUEUE_DEPTH[QUEUE_PTR:0];

  logic [QUEUE_DEPTH-1:0] b_mem;
  logic [QUEUE_PTR-1:0]   b_wr_ptr;
  logic [QUEUE_PTR-1:0]   b_rd_ptr;
  logic [QUEUE_PTR:0]     b_count;

  logic pushOk;
  logic popOk;

  assign oFULL  = (b_count == L_FULL_COUNT);
  assign oEMPTY = (b_count == '0);
  assign oHEAD  = b_mem[b_rd_ptr];

  assign pushOk = iPUSH && !oFULL;
  assign popOk  = iPOP && !oEMPTY;

  // Pointers are exactly QUEUE_PTR bits wide, so they wrap modulo QUEUE_DEPTH.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_mem    <= '0;
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      b_count  <= '0;
    end else begin
      if (pushOk) begin
        b_mem[b_wr_ptr] <= iDATA;
        b_wr_ptr        <= b_wr_ptr + QUEUE_PTR'(1);
      end
      if (popOk) begin
        b_rd_ptr <= b_rd_ptr + QUEUE_PTR'(1);
      end
      case ({pushOk, popOk})
        2'b10:   b_count <= b_count + (QUEUE_PTR + 1)'(1);
        2'b01:   b_count <= b_count - (QUEUE_PTR + 1)'(1);
        default: b_count <= b_count;
      endcase
    end
  end

endmodule

// File: rtl/mmu_request_arbiter.sv
// Shares the single MMU request port between instruction fetch (IF) and
// load/store (LS). Round-robin arbitration with a sticky grant while the MMU
// stalls; accepted reads are tracked in an in-order owner queue so returning
// data and page faults are routed back to the right requester.
// Ports:
//   iCLOCK, inRESET                     : clock, asynchronous active-low reset
//   iIF_REQ/iIF_ADDR, oIF_LOCK          : fetch request (always a read) / stall
//   oIF_VALID/oIF_DATA/oIF_PAGEFAULT    : fetch response
//   iLS_REQ/iLS_DATA_STORE_ACK/iLS_ORDER/iLS_RW/iLS_ADDR/iLS_DATA, oLS_LOCK
//                                       : load/store request / stall
//   oLS_VALID/oLS_DATA/oLS_PAGEFAULT    : load/store response
//   iSYS_MODE/iSYS_PDT                  : paging mode / PDT, passed through
//   oMMU_* / iMMU_LOCK                  : request to the MMU / MMU stall
//   iMMU_VALID/iMMU_DATA/iMMU_PAGEFAULT : read return / page fault
module mmu_request_arbiter
  import mmu_request_arbiter_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned QUEUE_PTR   = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iIF_REQ,
  output logic        oIF_LOCK,
  input  logic [31:0] iIF_ADDR,
  output logic        oIF_VALID,
  output logic [63:0] oIF_DATA,
  output logic        oIF_PAGEFAULT,
  input  logic        iLS_REQ,
  output logic        oLS_LOCK,
  input  logic        iLS_DATA_STORE_ACK,
  input  logic [1:0]  iLS_ORDER,
  input  logic        iLS_RW,
  input  logic [31:0] iLS_ADDR,
  input  logic [31:0] iLS_DATA,
  output logic        oLS_VALID,
  output logic [63:0] oLS_DATA,
  output logic        oLS_PAGEFAULT,
  input  logic [1:0]  iSYS_MODE,
  input  logic [31:0] iSYS_PDT,
  output logic        oMMU_REQ,
  input  logic        iMMU_LOCK,
  output logic        oMMU_DATA_STORE_ACK,
  output logic [1:0]  oMMU_MODE,
  output logic [31:0] oMMU_PDT,
  output logic [1:0]  oMMU_ORDER,
  output logic        oMMU_RW,
  output logic [31:0] oMMU_ADDR,
  output logic [31:0] oMMU_DATA,
  input  logic        iMMU_VALID,
  input  logic [63:0] iMMU_DATA,
  input  logic        iMMU_PAGEFAULT
);

  logic b_hold;
  logic b_hold_owner;
  logic b_last_grant;
  logic b_last_accepted_owner;
  logic b_last_accepted_read;
  logic b_err;

  logic grantValid;
  logic grantOwner;
  logic grantIsIf;
  logic holdReq;
  logic accept;
  logic acceptRead;
  logic queuePop;
  logic queueFull;
  logic queueEmpty;
  logic queueHead;
  logic returnOk;

  assign holdReq = (b_hold_owner == L_PARAM_OWNER_IF) ? iIF_REQ : iLS_REQ;

  always_comb begin
    grantValid = 1'b0;
    grantOwner = L_PARAM_OWNER_LS;
    if (b_hold && holdReq) begin
      grantValid = 1'b1;
      grantOwner = b_hold_owner;
    end else if (iIF_REQ && iLS_REQ) begin
      grantValid = 1'b1;
      grantOwner = ~b_last_grant;
    end else if (iIF_REQ) begin
      grantValid = 1'b1;
      grantOwner = L_PARAM_OWNER_IF;
    end else if (iLS_REQ) begin
      grantValid = 1'b1;
      grantOwner = L_PARAM_OWNER_LS;
    end
  end

  assign grantIsIf  = grantValid && (grantOwner == L_PARAM_OWNER_IF);
  // A full queue blocks writes too, so store ordering never overtakes reads.
  assign oMMU_REQ   = grantValid && !queueFull;
  assign accept     = oMMU_REQ && !iMMU_LOCK;
  assign acceptRead = accept && (grantIsIf || !iLS_RW);

  // With no grant the fields default to the LS side.
  assign oMMU_DATA_STORE_ACK = grantIsIf ? 1'b0             : iLS_DATA_STORE_ACK;
  assign oMMU_ORDER          = grantIsIf ? L_PARAM_IF_ORDER : iLS_ORDER;
  assign oMMU_RW             = grantIsIf ? 1'b0             : iLS_RW;
  assign oMMU_ADDR           = grantIsIf ? iIF_ADDR         : iLS_ADDR;
  assign oMMU_DATA           = grantIsIf ? 32'h0            : iLS_DATA;
  assign oMMU_MODE           = iSYS_MODE;
  assign oMMU_PDT            = iSYS_PDT;

  assign oIF_LOCK = !(accept && grantIsIf) && (iMMU_LOCK || queueFull || iIF_REQ);
  assign oLS_LOCK = !(accept && !grantIsIf) && (iMMU_LOCK || queueFull || iLS_REQ);

  // A faulting read never returns data, so its queue entry is retired here.
  assign queuePop = iMMU_VALID || (iMMU_PAGEFAULT && b_last_accepted_read);
  assign returnOk = iMMU_VALID && !queueEmpty;

  assign oIF_VALID     = returnOk && (queueHead == L_PARAM_OWNER_IF);
  assign oLS_VALID     = returnOk && (queueHead == L_PARAM_OWNER_LS);
  assign oIF_DATA      = oIF_VALID ? iMMU_DATA : 64'h0;
  assign oLS_DATA      = oLS_VALID ? iMMU_DATA : 64'h0;
  assign oIF_PAGEFAULT = iMMU_PAGEFAULT && (b_last_accepted_owner == L_PARAM_OWNER_IF);
  assign oLS_PAGEFAULT = iMMU_PAGEFAULT && (b_last_accepted_owner == L_PARAM_OWNER_LS);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_hold                <= 1'b0;
      b_hold_owner          <= L_PARAM_OWNER_LS;
      b_last_grant          <= L_PARAM_OWNER_LS;
      b_last_accepted_owner <= L_PARAM_OWNER_LS;
      b_last_accepted_read  <= 1'b0;
      b_err                 <= 1'b0;
    end else begin
      b_hold <= grantValid && !accept;
      if (grantValid) begin
        b_hold_owner <= grantOwner;
      end
      if (accept) begin
        b_last_grant          <= grantOwner;
        b_last_accepted_owner <= grantOwner;
        b_last_accepted_read  <= acceptRead;
      end
      if (iMMU_VALID && queueEmpty) begin
        b_err <= 1'b1;
      end
    end
  end

  mmu_arbiter_owner_fifo #(
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .QUEUE_PTR  (QUEUE_PTR)
  ) u_owner_fifo (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .iPUSH  (acceptRead),
    .iDATA  (grantOwner),
    .iPOP   (queuePop),
    .oFULL  (queueFull),
    .oEMPTY (queueEmpty),
    .oHEAD  (queueHead)
  );

endmodule

// File: tb/tb_mmu_request_arbiter.sv
module tb_mmu_request_arbiter;
  import mmu_request_arbiter_pkg::*;

  localparam logic [31:0] IF_ADDR  = 32'h0000_1000;
  localparam logic [31:0] LS_ADDR  = 32'h0000_2000;
  localparam logic [31:0] LS_WDATA = 32'hCAFE_0001;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iIF_REQ, oIF_LOCK, oIF_VALID, oIF_PAGEFAULT;
  logic [31:0] iIF_ADDR;
  logic [63:0] oIF_DATA;
  logic        iLS_REQ, oLS_LOCK, iLS_DATA_STORE_ACK, iLS_RW, oLS_VALID, oLS_PAGEFAULT;
  logic [1:0]  iLS_ORDER;
  logic [31:0] iLS_ADDR, iLS_DATA;
  logic [63:0] oLS_DATA;
  logic [1:0]  iSYS_MODE;
  logic [31:0] iSYS_PDT;
  logic        oMMU_REQ, iMMU_LOCK, oMMU_DATA_STORE_ACK, oMMU_RW;
  logic [1:0]  oMMU_MODE, oMMU_ORDER;
  logic [31:0] oMMU_PDT, oMMU_ADDR, oMMU_DATA;
  logic        iMMU_VALID, iMMU_PAGEFAULT;
  logic [63:0] iMMU_DATA;

  always #5 iCLOCK = ~iCLOCK;

  mmu_request_arbiter dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iIF_REQ(iIF_REQ), .oIF_LOCK(oIF_LOCK), .iIF_ADDR(iIF_ADDR),
    .oIF_VALID(oIF_VALID), .oIF_DATA(oIF_DATA), .oIF_PAGEFAULT(oIF_PAGEFAULT),
    .iLS_REQ(iLS_REQ), .oLS_LOCK(oLS_LOCK), .iLS_DATA_STORE_ACK(iLS_DATA_STORE_ACK),
    .iLS_ORDER(iLS_ORDER), .iLS_RW(iLS_RW), .iLS_ADDR(iLS_ADDR), .iLS_DATA(iLS_DATA),
    .oLS_VALID(oLS_VALID), .oLS_DATA(oLS_DATA), .oLS_PAGEFAULT(oLS_PAGEFAULT),
    .iSYS_MODE(iSYS_MODE), .iSYS_PDT(iSYS_PDT),
    .oMMU_REQ(oMMU_REQ), .iMMU_LOCK(iMMU_LOCK), .oMMU_DATA_STORE_ACK(oMMU_DATA_STORE_ACK),
    .oMMU_MODE(oMMU_MODE), .oMMU_PDT(oMMU_PDT), .oMMU_ORDER(oMMU_ORDER),
    .oMMU_RW(oMMU_RW), .oMMU_ADDR(oMMU_ADDR), .oMMU_DATA(oMMU_DATA),
    .iMMU_VALID(iMMU_VALID), .iMMU_DATA(iMMU_DATA), .iMMU_PAGEFAULT(iMMU_PAGEFAULT)
  );

  typedef struct packed {
    logic        owner;
    logic [63:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct packed {
    logic        ifReq, lsReq, lsRw, lock;
    logic        expReq, expIfLock, expLsLock;
    logic        doPush, pushOwner;
    logic [31:0] expAddr;
  } vec_t;
  vec_t vecs[9];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic idle();
    iIF_REQ = 1'b0; iLS_REQ = 1'b0; iLS_RW = 1'b0; iMMU_LOCK = 1'b0;
    iMMU_VALID = 1'b0; iMMU_PAGEFAULT = 1'b0; iMMU_DATA = 64'h0;
  endtask

  task automatic expect_push(input logic owner);
    sb_t e;
    e.owner = owner;
    e.data  = {$urandom(), $urandom()};
    sbq.push_back(e);
  endtask

  // Returns one read per cycle and checks routing against the scoreboard head.
  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      iMMU_VALID = 1'b1;
      iMMU_DATA  = e.data;
      @(negedge iCLOCK);
      chk("ret_if_valid", 64'(oIF_VALID), 64'(e.owner == L_PARAM_OWNER_IF));
      chk("ret_ls_valid", 64'(oLS_VALID), 64'(e.owner == L_PARAM_OWNER_LS));
      if (e.owner == L_PARAM_OWNER_IF) chk("ret_if_data", oIF_DATA, e.data);
      else                             chk("ret_ls_data", oLS_DATA, e.data);
      step();
      iMMU_VALID = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LS_ADDR};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, L_PARAM_OWNER_IF, IF_ADDR};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LS_ADDR};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, LS_ADDR};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LS_ADDR};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, L_PARAM_OWNER_IF, IF_ADDR};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, L_PARAM_OWNER_LS, LS_ADDR};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IF_ADDR};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, L_PARAM_OWNER_IF, IF_ADDR};

    idle();
    iIF_ADDR = IF_ADDR; iLS_ADDR = LS_ADDR; iLS_DATA = LS_WDATA;
    iLS_ORDER = 2'h1; iLS_DATA_STORE_ACK = 1'b0;
    iSYS_MODE = 2'h1; iSYS_PDT = 32'h0008_0000;
    inRESET = 1'b0;
    repeat (3) step();

    // Reset state.
    chk("rst_mmu_req", 64'(oMMU_REQ), 64'd0);
    chk("rst_if_lock", 64'(oIF_LOCK), 64'd0);
    chk("rst_ls_lock", 64'(oLS_LOCK), 64'd0);
    chk("rst_valids", 64'({oIF_VALID, oLS_VALID}), 64'd0);
    chk("rst_pfs", 64'({oIF_PAGEFAULT, oLS_PAGEFAULT}), 64'd0);
    chk("rst_err", 64'(dut.b_err), 64'd0);
    inRESET = 1'b1;
    step();

    // Arbitration table starting from the reset state.
    for (int i = 0; i < 9; i++) begin
      iIF_REQ = vecs[i].ifReq; iLS_REQ = vecs[i].lsReq;
      iLS_RW = vecs[i].lsRw; iMMU_LOCK = vecs[i].lock;
      @(negedge iCLOCK);
      chk($sformatf("vec%0d_req", i), 64'(oMMU_REQ), 64'(vecs[i].expReq));
      chk($sformatf("vec%0d_if_lock", i), 64'(oIF_LOCK), 64'(vecs[i].expIfLock));
      chk($sformatf("vec%0d_ls_lock", i), 64'(oLS_LOCK), 64'(vecs[i].expLsLock));
      chk($sformatf("vec%0d_addr", i), 64'(oMMU_ADDR), 64'(vecs[i].expAddr));
      if (vecs[i].doPush) expect_push(vecs[i].pushOwner);
      step();
    end
    idle();
    drain();

    // IF only, return three cycles after acceptance.
    iIF_REQ = 1'b1;
    @(negedge iCLOCK);
    chk("ifonly_req", 64'(oMMU_REQ), 64'd1);
    chk("ifonly_order", 64'(oMMU_ORDER), 64'h2);
    chk("ifonly_pass_pdt", 64'(oMMU_PDT), 64'h0008_0000);
    sbq.push_back('{L_PARAM_OWNER_IF, 64'hDEAD_BEEF_0123_4567});
    step();
    idle();
    repeat (2) step();
    drain();

    // Round-robin tie: last grant was IF, so LS leads.
    iIF_REQ = 1'b1; iLS_REQ = 1'b1; iLS_RW = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLOCK);
      chk($sformatf("rr%0d_addr", i), 64'(oMMU_ADDR), 64'((i % 2 == 0) ? LS_ADDR : IF_ADDR));
      expect_push((i % 2 == 0) ? L_PARAM_OWNER_LS : L_PARAM_OWNER_IF);
      step();
    end
    idle();
    drain();

    // Sticky grant: LS held through 4 locked cycles while IF waits.
    iLS_REQ = 1'b1; iLS_RW = 1'b0; iMMU_LOCK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) iIF_REQ = 1'b1;
      @(negedge iCLOCK);
      chk($sformatf("sticky%0d_addr", i), 64'(oMMU_ADDR), 64'(LS_ADDR));
      chk($sformatf("sticky%0d_ls_lock", i), 64'(oLS_LOCK), 64'd1);
      step();
    end
    iMMU_LOCK = 1'b0;
    @(negedge iCLOCK);
    chk("sticky_acc_ls_lock", 64'(oLS_LOCK), 64'd0);
    chk("sticky_acc_if_lock", 64'(oIF_LOCK), 64'd1);
    chk("sticky_acc_addr", 64'(oMMU_ADDR), 64'(LS_ADDR));
    expect_push(L_PARAM_OWNER_LS);
    step();
    iLS_REQ = 1'b0;
    @(negedge iCLOCK);
    chk("sticky_if_next_addr", 64'(oMMU_ADDR), 64'(IF_ADDR));
    chk("sticky_if_next_lock", 64'(oIF_LOCK), 64'd0);
    expect_push(L_PARAM_OWNER_IF);
    step();
    idle();
    drain();

    // Full queue: eight reads fill it, the ninth waits for one return.
    iIF_REQ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLOCK);
      chk($sformatf("fill%0d_if_lock", i), 64'(oIF_LOCK), 64'd0);
      expect_push(L_PARAM_OWNER_IF);
      step();
    end
    @(negedge iCLOCK);
    chk("full_if_lock", 64'(oIF_LOCK), 64'd1);
    chk("full_mmu_req", 64'(oMMU_REQ), 64'd0);
    step();
    begin
      sb_t e;
      e = sbq.pop_front();
      iMMU_VALID = 1'b1; iMMU_DATA = e.data;
      @(negedge iCLOCK);
      chk("full_pop_valid", 64'(oIF_VALID), 64'd1);
      chk("full_pop_data", oIF_DATA, e.data);
      chk("full_pop_still_locked", 64'(oIF_LOCK), 64'd1);
      step();
    end
    iMMU_VALID = 1'b0;
    @(negedge iCLOCK);
    chk("ninth_mmu_req", 64'(oMMU_REQ), 64'd1);
    chk("ninth_if_lock", 64'(oIF_LOCK), 64'd0);
    expect_push(L_PARAM_OWNER_IF);
    step();
    idle();
    drain();

    // Write does not queue.
    iLS_REQ = 1'b1; iLS_RW = 1'b1;
    @(negedge iCLOCK);
    chk("wr_ls_lock", 64'(oLS_LOCK), 64'd0);
    chk("wr_rw", 64'(oMMU_RW), 64'd1);
    chk("wr_data", 64'(oMMU_DATA), 64'(LS_WDATA));
    step();
    idle();
    iIF_REQ = 1'b1;
    @(negedge iCLOCK);
    chk("wr_then_if_lock", 64'(oIF_LOCK), 64'd0);
    expect_push(L_PARAM_OWNER_IF);
    step();
    idle();
    drain();
    chk("wr_queue_empty", 64'(dut.queueEmpty), 64'd1);

    // Page fault on an LS read retires its entry.
    iLS_REQ = 1'b1; iLS_RW = 1'b0;
    step();
    idle();
    iMMU_PAGEFAULT = 1'b1;
    @(negedge iCLOCK);
    chk("pf_ls", 64'(oLS_PAGEFAULT), 64'd1);
    chk("pf_if", 64'(oIF_PAGEFAULT), 64'd0);
    chk("pf_no_valid", 64'({oIF_VALID, oLS_VALID}), 64'd0);
    step();
    iMMU_PAGEFAULT = 1'b0;
    @(negedge iCLOCK);
    chk("pf_pulse_end", 64'(oLS_PAGEFAULT), 64'd0);
    chk("pf_queue_empty", 64'(dut.queueEmpty), 64'd1);
    step();

    // Reset with three reads outstanding.
    iIF_REQ = 1'b1;
    repeat (3) step();
    idle();
    inRESET = 1'b0;
    #2;
    chk("mid_rst_req", 64'(oMMU_REQ), 64'd0);
    chk("mid_rst_locks", 64'({oIF_LOCK, oLS_LOCK}), 64'd0);
    chk("mid_rst_valids", 64'({oIF_VALID, oLS_VALID}), 64'd0);
    chk("mid_rst_pfs", 64'({oIF_PAGEFAULT, oLS_PAGEFAULT}), 64'd0);
    chk("mid_rst_empty", 64'(dut.queueEmpty), 64'd1);
    step();
    inRESET = 1'b1;
    step();
    iMMU_VALID = 1'b1; iMMU_DATA = 64'h1111_2222_3333_4444;
    @(negedge iCLOCK);
    chk("empty_pop_valids", 64'({oIF_VALID, oLS_VALID}), 64'd0);
    step();
    iMMU_VALID = 1'b0;
    chk("empty_pop_err", 64'(dut.b_err), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmu_request_arbiter.md
Name: mmu_request_arbiter

Overview:
- Shares the single MMU request port between the instruction-fetch (IF) and load/store (LS) requesters.
- Applies round-robin arbitration with a sticky grant, so a request stalled by MMU lock keeps its grant.
- Tracks outstanding reads in an in-order owner queue and routes returning 64-bit read data and page faults back to the owning requester.
- Sits between the core memory stages and the MMU's logic-address request interface.

Parameters:
- QUEUE_DEPTH, 8, maximum outstanding reads; must be a power of two.
- QUEUE_PTR, 3, log2(QUEUE_DEPTH).

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  asynchronous active-low reset.
- iIF_REQ / oIF_LOCK  in / out  1 / 1  fetch request; fetch stall.
- iIF_ADDR  in  32  fetch logical address. Fetch is always a read with order 2'h2.
- oIF_VALID / oIF_DATA / oIF_PAGEFAULT  out  1 / 64 / 1  fetch response.
- iLS_REQ / oLS_LOCK  in / out  1 / 1  load/store request; load/store stall.
- iLS_DATA_STORE_ACK  in  1  store-ack flag, passed to the MMU.
- iLS_ORDER  in  2  access size, passed to the MMU.
- iLS_RW  in  1  0 = read, 1 = write.
- iLS_ADDR / iLS_DATA  in  32 / 32  load/store address and store data.
- oLS_VALID / oLS_DATA / oLS_PAGEFAULT  out  1 / 64 / 1  load/store response.
- iSYS_MODE / iSYS_PDT  in  2 / 32  paging mode and page-directory table; passed through unchanged.
- oMMU_REQ  out  1  request to the MMU.
- iMMU_LOCK  in  1  MMU not accepting.
- oMMU_DATA_STORE_ACK, oMMU_MODE, oMMU_PDT, oMMU_ORDER, oMMU_RW, oMMU_ADDR, oMMU_DATA  out  1 / 2 / 32 / 2 / 1 / 32 / 32  request fields to the MMU.
- iMMU_VALID / iMMU_DATA  in  1 / 64  read return.
- iMMU_PAGEFAULT  in  1  page fault for the most recently accepted request.

Behaviour:
- **Acceptance:** a request is accepted when oMMU_REQ && !iMMU_LOCK in the same cycle.
- **Grant selection (combinational):**
  - If b_hold = 1, grant goes to b_hold_owner.
  - Else, if only one requester asserts REQ, that requester is granted.
  - Else, if both assert, grant goes to the requester that was not b_last_grant.
- **Request output:** oMMU_REQ = granted request && !queue_full. The oMMU_* fields are muxed from the granted requester; when there is no grant, they carry the LS fields.
- **Lock outputs:**
  - A requester's LOCK = iMMU_LOCK || queue_full || (its REQ is high and it is not the accepted requester this cycle).
  - The accepted requester sees LOCK = 0.
- **Hold state:** b_hold sets when a granted request is not accepted, and clears on acceptance.
- **Last grant:** b_last_grant updates to the accepted owner on every acceptance.
- **Owner queue:**
  - Every accepted read (IF, or LS with RW = 0) pushes the owner ID.
  - Writes do not push.
  - iMMU_VALID pops the head. The pop routes iMMU_DATA to that owner's DATA output, with VALID asserted the same cycle (zero latency); the other requester's VALID stays 0.
- **Page fault:** iMMU_PAGEFAULT asserts the PAGEFAULT output of b_last_accepted_owner for one cycle. If that request was a read, its queue entry is also popped (no data returns).
- **Simultaneous push and pop:** the occupancy count is unchanged.
- **Full queue:** no new read is accepted; writes are also blocked (no bypass).
- **Empty queue:** iMMU_VALID is an error; the pop is ignored, both VALID outputs stay 0, and the sticky bit b_err sets (debug visibility only).
- **Pointer wrap:** pointers wrap modulo QUEUE_DEPTH. Count width is QUEUE_PTR+1.
- **Reset (asynchronous):**
  - Queue emptied; b_hold = 0; b_last_grant = LS (so IF wins the first tie); b_err = 0.
  - All VALID and PAGEFAULT outputs are 0; oMMU_REQ = 0; both LOCKs = 0.
  - Reset mid-transaction discards all outstanding entries.

Decomposition:
- Shared package holds:
  - Owner ID constants: L_PARAM_OWNER_IF = 1'b0, L_PARAM_OWNER_LS = 1'b1.
  - Fetch order constant 2'h2.
- Sub-module: mmu_arbiter_owner_fifo, a QUEUE_DEPTH x 1-bit synchronous FIFO with push, pop, full, empty and head outputs.

Test Plan:
- **IF only:** IF read 0x0000_1000; MMU returns 0xDEAD_BEEF_0123_4567 three cycles later -> oIF_VALID = 1 with that data; oLS_VALID = 0.
- **Round-robin tie:** both request every cycle with no lock -> grants alternate IF, LS, IF, LS; returns route in push order.
- **Sticky grant:** LS granted while iMMU_LOCK = 1 for 4 cycles and IF requests meanwhile -> LS fields are held stable, accepted on cycle 5; IF is granted the next cycle.
- **Full queue:** 8 IF reads with no returns -> the ninth is blocked (oIF_LOCK = 1, oMMU_REQ = 0). One iMMU_VALID -> the next cycle, the ninth read is accepted.
- **Write does not queue:** LS write, then IF read; one iMMU_VALID -> routed to IF; queue empty afterwards.
- **Page fault and reset:** LS read followed by iMMU_PAGEFAULT -> oLS_PAGEFAULT pulses one cycle and the queue is empty. Asserting inRESET with 3 reads outstanding -> all outputs return to 0 and a later iMMU_VALID sets b_err without asserting any VALID.
